// File: rtl/dwnsmp_pkg.sv
// Shared communications-chain parameters for the filter, sync and downsampler blocks.
// Also provides a helper that sizes the phase counter from the oversampling factor.
package dwnsmp_pkg;

  localparam int unsigned CC_OS     = 4;
  localparam int unsigned CC_S_COEF = 8;
  localparam int unsigned CC_S_IN   = 2;
  localparam int unsigned CC_S_OUT  = CC_S_COEF + CC_S_IN;

  // Phase counter width; clamped to 1 so a degenerate OS still elaborates.
  function automatic int unsigned fase_w(input int unsigned os);
    return (os < 2) ? 1 : $clog2(os);
  endfunction

  localparam int unsigned CC_FASE = fase_w(CC_OS);

endpackage

// File: rtl/dwnsmp_phase_cnt.sv
// Symbol phase counter with sync realignment; reports the phase of the sample
// presented in the current cycle and advances only when told to.
module dwnsmp_phase_cnt
  import dwnsmp_pkg::*;
#(
  parameter int unsigned OS   = CC_OS,
  parameter int unsigned FASE = fase_w(OS)
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic            i_adv,
  input  logic            i_sync,
  output logic [FASE-1:0] o_phase
);

  logic [FASE-1:0] cnt_q, cnt_d;

  // A sync sample is phase 0 regardless of where the counter stood.
  always_comb begin
    o_phase = i_sync ? '0 : cnt_q;
  end

  // OS is a power of two, so natural FASE-bit overflow gives the OS-1 -> 0 wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (i_adv) begin
      cnt_d = o_phase + FASE'(1);
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dwnsmp.sv
// Symbol-rate downsampler: keeps one RC-filter sample per symbol, chosen by i_fase,
// and holds it on a registered output until the next selected sample.
module dwnsmp
  import dwnsmp_pkg::*;
#(
  parameter int unsigned OS     = CC_OS,
  parameter int unsigned S_COEF = CC_S_COEF,
  parameter int unsigned S_IN   = CC_S_IN,
  parameter int unsigned S_OUT  = S_COEF + S_IN
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_valid,
  input  logic [OS-1:0]           i_fase,
  input  logic signed [S_OUT-1:0] i_rc_filter,
  input  logic                    i_sync,
  output logic signed [S_OUT-1:0] o_dwnsmp
);

  localparam int unsigned FASE = fase_w(OS);

  if (OS < 2 || (OS & (OS - 1)) != 0) begin : g_bad_os
    $error("dwnsmp: OS must be a power of two and at least 2");
  end

  logic                    adv;
  logic [FASE-1:0]         phase;
  logic [FASE-1:0]         fase_sel;
  logic                    hit;
  logic signed [S_OUT-1:0] out_q, out_d;

  assign adv      = i_enable & i_valid;
  assign fase_sel = i_fase[FASE-1:0];

  // Only the low FASE bits select a phase; the rest of the bus is don't-care.
  logic unused_fase;
  assign unused_fase = ^i_fase[OS-1:FASE];

  dwnsmp_phase_cnt #(
    .OS   (OS),
    .FASE (FASE)
  ) u_phase_cnt (
    .clock   (clock),
    .i_reset (i_reset),
    .i_adv   (adv),
    .i_sync  (i_sync),
    .o_phase (phase)
  );

  assign hit = adv && (phase == fase_sel);

  always_comb begin
    out_d = out_q;
    if (hit) begin
      out_d = i_rc_filter;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign o_dwnsmp = out_q;

endmodule

// File: tb/tb_dwnsmp.sv
// Scoreboard bench for dwnsmp: stimulus pushes hand-determined captures into a queue,
// a negedge monitor pops them when due and otherwise checks that the output holds.
module tb_dwnsmp;

  localparam int unsigned OS = 4;
  localparam int unsigned SW = 10;

  typedef struct packed {
    int            due;
    logic [SW-1:0] val;
  } exp_t;

  logic          clock = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic          i_valid;
  logic [OS-1:0] i_fase;
  logic [SW-1:0] i_rc_filter;
  logic          i_sync;
  logic [SW-1:0] o_dwnsmp;

  int            cyc   = 0;
  int            total = 0;
  int            bad   = 0;
  exp_t          q[$];
  logic [SW-1:0] exp_hold = '0;

  dwnsmp #(
    .OS     (OS),
    .S_COEF (8),
    .S_IN   (2),
    .S_OUT  (SW)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_fase      (i_fase),
    .i_rc_filter (i_rc_filter),
    .i_sync      (i_sync),
    .o_dwnsmp    (o_dwnsmp)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  // Drive one cycle; cap=1 means this sample must appear on o_dwnsmp one clock later.
  task automatic send(input logic en, input logic v, input logic s,
                      input logic [SW-1:0] d, input bit cap);
    i_enable    = en;
    i_valid     = v;
    i_sync      = s;
    i_rc_filter = d;
    if (cap) q.push_back('{due: cyc + 1, val: d});
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!i_reset) begin
      exp_hold = '0;
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("late_capture", o_dwnsmp, q[0].val);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_hold = q[0].val;
        void'(q.pop_front());
        check("capture", o_dwnsmp, exp_hold);
      end else begin
        check("hold", o_dwnsmp, exp_hold);
      end
    end
  end

  initial begin
    i_reset     = 1'b0;
    i_enable    = 1'b0;
    i_valid     = 1'b0;
    i_sync      = 1'b0;
    i_fase      = '0;
    i_rc_filter = '0;

    // Reset held with random activity on every input.
    repeat (5) begin
      i_enable    = 1'($urandom);
      i_valid     = 1'($urandom);
      i_sync      = 1'($urandom);
      i_fase      = OS'($urandom);
      i_rc_filter = SW'($urandom);
      @(posedge clock);
      #1;
      check("reset_hold", o_dwnsmp, '0);
    end
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    @(posedge clock);
    #1;

    // Phase 3 select on ramp 0..79, sync every 4th sample.
    i_fase = 4'd3;
    for (int i = 0; i < 80; i++) send(1, 1, (i % 4) == 0, SW'(i), (i % 4) == 3);

    // Sweep all phases; odd phases use negative samples counting down from 10'h3FF.
    for (int f = 0; f < 4; f++) begin
      i_fase = OS'(f);
      for (int i = 0; i < 80; i++) begin
        logic [SW-1:0] d;
        d = (f % 2 == 1) ? SW'(10'h3FF - i) : SW'(i);
        send(1, 1, (i % 4) == 0, d, (i % 4) == f);
      end
    end

    // Stalls mid-symbol: sync and data offered during stalls must be ignored.
    i_fase = 4'd3;
    for (int i = 0; i < 6; i++) send(1, 1, (i % 4) == 0, SW'(100 + i), (i % 4) == 3);
    repeat (3) send(1, 0, 1, SW'($urandom), 0);
    repeat (2) send(0, 1, 1, SW'($urandom), 0);
    for (int i = 6; i < 16; i++) send(1, 1, (i % 4) == 0, SW'(100 + i), (i % 4) == 3);

    // Resync at counter phase 2, then natural wrap back to phase 0.
    i_fase = 4'd0;
    send(1, 1, 1, SW'(200), 1);
    send(1, 1, 0, SW'(201), 0);
    send(1, 1, 1, SW'(202), 1);
    send(1, 1, 0, SW'(203), 0);
    send(1, 1, 0, SW'(204), 0);
    send(1, 1, 0, SW'(205), 0);
    send(1, 1, 0, SW'(206), 1);
    repeat (2) send(0, 0, 0, '0, 0);

    // Asynchronous clear between clock edges with the counter at phase 1.
    #2;
    i_reset = 1'b0;
    q.delete();
    #1;
    check("async_clear", o_dwnsmp, '0);
    @(posedge clock);
    #1;
    check("async_clear_edge", o_dwnsmp, '0);
    i_reset = 1'b1;

    // First advance after reset is phase 0 without sync; upper i_fase bits ignored.
    i_fase = 4'b0100;
    send(1, 1, 0, SW'(300), 1);
    send(1, 1, 0, SW'(301), 0);
    send(1, 1, 0, SW'(302), 0);
    send(1, 1, 0, SW'(303), 0);
    send(1, 1, 0, SW'(304), 1);
    repeat (3) send(0, 0, 0, '0, 0);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d left want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
